stream_seq_src: RTL
===================

# stream_seq_src

Synthesizable valid/ready stream transmitter that emits a programmed-length incrementing byte sequence with configurable inter-beat gaps. It sits upstream of `ready_proxy` and other valid/ready pipeline stages, driving their `up_*` side in bring-up and self-test builds. It makes the stimulus side of handshake stages available as hardware. It pairs with a downstream sequence checker.

## Interface
Parameters:
- `DATA_W`, 8: data width; sequence wraps modulo 2^DATA_W.
- `CNT_W`, 16: width of beat length and beat counter.
- `LFSR_SEED`, 16'hACE1: reset and start seed of the gap LFSR; must be nonzero.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to begin a burst; honoured only in IDLE.
- `len` in CNT_W: number of beats; sampled when `start` is accepted.
- `base` in DATA_W: value of the first beat; sampled with `start`.
- `gap_mode` in 2: 0 none, 1 fixed, 2 alternate, 3 random; sampled with `start`.
- `gap_len` in 4: idle cycles per gap in mode 1; sampled with `start`.
- `down_data` out DATA_W: beat payload.
- `down_valid` out 1: beat offered.
- `down_ready` in 1: downstream accepts when high together with `down_valid`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse at burst end.
- `sent_cnt` out CNT_W: beats accepted in the current or last burst.

## Operation
- All outputs are registered. Reset values: `down_data`=0, `down_valid`=0, `busy`=0, `done`=0, `sent_cnt`=0. The FSM resets to IDLE and the LFSR to `LFSR_SEED`.
- FSM states:
  - IDLE: on `start`, latch the config, clear `sent_cnt`, and reseed the LFSR. If `len`=0, go to DONE; otherwise go to SEND with `down_valid`=1 and `down_data`=`base`.
  - SEND: `down_valid`=1. On accept (`down_valid && down_ready`), increment `sent_cnt`.
    - If this was the last beat, go to DONE.
    - Otherwise, if a gap applies, go to GAP with `down_valid`=0.
    - Otherwise stay in SEND with `down_data`+1.
  - GAP: `down_valid`=0 while the gap counter runs down. At 0, return to SEND with the next data value.
  - DONE: `done`=1 and `busy`=1 for one cycle, then go to IDLE.
- Gap length after each accepted beat:
  - Mode 0: 0.
  - Mode 1: `gap_len`; `gap_len`=0 behaves as mode 0.
  - Mode 2: 1 after every odd-numbered accepted beat (1st, 3rd, …), otherwise 0.
  - Mode 3: see Configuration.
- Handshake rules:
  - Once asserted, `down_valid` stays high until accepted.
  - `down_data` is stable while `down_valid && !down_ready`.
  - `down_valid` never depends combinationally on `down_ready`.
- Boundaries:
  - `start` while not IDLE is ignored.
  - Changes to the config inputs mid-burst have no effect.
  - `sent_cnt` never exceeds `len`.
  - `len`=2^CNT_W−1 completes without counter overflow.
  - `down_data` wraps from 2^DATA_W−1 to 0.
  - Reset mid-burst drops `down_valid` and `busy` immediately (asynchronously). No `done` is produced.

## Timing
- Latency: with `start` at cycle N, `down_valid` is high at N+1.
- Throughput: mode 0 with `down_ready` held high gives one beat per cycle, so `len` beats occupy cycles N+1..N+len.
- `done` occurs in the cycle after the last accept: cycle N+len+1 in mode 0 with no stall. With `len`=0, `done` is at N+1.
- A new `start` is accepted at the earliest in the cycle after `done`.
- Each gap of G cycles inserts exactly G cycles with `down_valid`=0 between accepts.

## Configuration
- `STREAM_SEQ_SRC_LFSR_EN` defined:
  - Builds a 16-bit Fibonacci LFSR with taps 16,14,13,11.
  - The LFSR steps on each accepted beat.
  - In mode 3, the gap equals the LFSR's low 2 bits (0–3 cycles).
- Not defined:
  - No LFSR logic is built.
  - Mode 3 behaves as mode 0.
  - `LFSR_SEED` is unused.

## Structure
- Package `stream_pkg`: the `gap_mode_t` enum (GAP_NONE, GAP_FIXED, GAP_ALT, GAP_RAND), the `src_state_t` enum (IDLE, SEND, GAP, DONE), and the LFSR tap constant.
- Sub-module `seq_lfsr`: 16-bit LFSR with `load`/`step` inputs. It is instantiated only under `STREAM_SEQ_SRC_LFSR_EN`.

## Test plan
- Mode 0, `len`=10, `base`=0, `down_ready`=1 → data 0..9 on 10 consecutive cycles; `done` one cycle after the beat with data 9; `sent_cnt`=10.
- Mode 1, `gap_len`=3, `len`=4, `base`=8'hFE, `down_ready`=1 → data FE, FF, 00, 01 with exactly 3 idle cycles between beats (wrap checked).
- Mode 0, `len`=6, `down_ready` toggling every cycle → each beat is held stable until accepted; no beat is lost or duplicated; `done` follows the 6th accept.
- `len`=0 → no `down_valid`; `done` and `busy` both high at N+1. A `start` pulsed while `busy` → ignored, and `sent_cnt` is unchanged.
- `rst_n` asserted mid-burst after 3 accepts → `down_valid`, `busy`, and `sent_cnt` go to 0 without a clock edge. A fresh `start` restarts from `base`.
- Mode 3 with the macro defined, `len`=20 → gaps within 0–3 cycles that match the LFSR model from `LFSR_SEED`. Without the macro → identical to mode 0.

Source files
------------

// File: rtl/stream_seq_src_pkg.sv
// stream_pkg: shared types and constants for the stream_seq_src burst
// transmitter. The LFSR tap constant is only consumed when the
// STREAM_SEQ_SRC_LFSR_EN macro is defined.

package stream_pkg;

    // Inter-beat gap policy, sampled at burst start
    typedef enum logic [1:0] {
        GAP_NONE  = 2'd0,
        GAP_FIXED = 2'd1,
        GAP_ALT   = 2'd2,
        GAP_RAND  = 2'd3
    } gap_mode_t;

    // Transmitter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } src_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/stream_seq_src_if.sv
// stream_seq_src_if: valid/ready byte stream between the sequence source
// (master) and a downstream consumer (slave).

interface stream_seq_src_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] down_data;
    logic              down_valid;
    logic              down_ready;

    modport master (
        output down_data,
        output down_valid,
        input  down_ready
    );

    modport slave (
        input  down_data,
        input  down_valid,
        output down_ready
    );
endinterface

// File: rtl/stream_seq_src_lfsr.sv
// seq_lfsr: 16-bit Fibonacci LFSR that supplies pseudo-random gap lengths.
// Only built when STREAM_SEQ_SRC_LFSR_EN is defined; the source exposes the
// two low bits because that is all the gap logic consumes.

`ifdef STREAM_SEQ_SRC_LFSR_EN
module seq_lfsr
    import stream_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [1:0] rand_bits
);

    logic [15:0] value;

    // Reseed on load, otherwise shift in the tap parity on each step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (step) begin
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

    assign rand_bits = value[1:0];

endmodule
`endif

// File: rtl/stream_seq_src.sv
// stream_seq_src: valid/ready transmitter emitting a programmed-length
// incrementing byte sequence with configurable inter-beat gaps.
// Optional feature macro: STREAM_SEQ_SRC_LFSR_EN (random gaps in mode 3;
// without it mode 3 sends back-to-back like mode 0).

module stream_seq_src
    import stream_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     len,
    input  logic [DATA_W-1:0]    base,
    input  logic [1:0]           gap_mode,
    input  logic [3:0]           gap_len,
    stream_seq_src_if.master     down,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sent_cnt
);

    src_state_t          state_q;
    src_state_t          state_d;

    logic [CNT_W-1:0]    len_q;
    gap_mode_t           mode_q;
    logic [3:0]          gap_len_q;

    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    sent_cnt_q;
    logic [3:0]          gap_cnt_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic                start_accept;
    logic                accept;
    logic                last_beat;
    logic [CNT_W-1:0]    sent_inc;
    logic [3:0]          gap_after;
    logic [1:0]          rand_bits;

    assign start_accept = (state_q == IDLE) && start;
    assign accept       = valid_q && down.down_ready;
    assign sent_inc     = sent_cnt_q + CNT_W'(1);
    // Comparing the post-increment count against len never needs a wider
    // counter, so len = 2^CNT_W-1 finishes cleanly.
    assign last_beat    = (sent_inc == len_q);

`ifdef STREAM_SEQ_SRC_LFSR_EN
    seq_lfsr #(
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start_accept),
        .step      (accept),
        .rand_bits (rand_bits)
    );
`else
    logic seed_unused;
    assign seed_unused = ^LFSR_SEED;
    assign rand_bits   = 2'b00;
`endif

    // Gap owed after the beat currently being accepted; the random mode uses
    // the LFSR value held at accept time, before it steps
    always_comb begin
        gap_after = 4'd0;
        case (mode_q)
            GAP_FIXED: gap_after = gap_len_q;
            GAP_ALT:   gap_after = sent_cnt_q[0] ? 4'd0 : 4'd1;
`ifdef STREAM_SEQ_SRC_LFSR_EN
            GAP_RAND:  gap_after = {2'b00, rand_bits};
`else
            GAP_RAND:  gap_after = {2'b00, rand_bits & 2'b00};
`endif
            default:   gap_after = 4'd0;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode for the burst sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end else if (gap_after != 4'd0) begin
                        state_d = GAP;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst configuration is captured only when a start is honoured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            mode_q    <= GAP_NONE;
            gap_len_q <= 4'd0;
        end else if (start_accept) begin
            len_q     <= len;
            mode_q    <= gap_mode_t'(gap_mode);
            gap_len_q <= gap_len;
        end
    end

    // Beat payload, accepted-beat count and gap countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            sent_cnt_q <= '0;
            gap_cnt_q  <= 4'd0;
        end else begin
            if (start_accept) begin
                data_q     <= base;
                sent_cnt_q <= '0;
                gap_cnt_q  <= 4'd0;
            end else if (accept) begin
                sent_cnt_q <= sent_inc;
                if (!last_beat) begin
                    data_q <= data_q + DATA_W'(1);
                    if (gap_after != 4'd0) begin
                        gap_cnt_q <= gap_after - 4'd1;
                    end
                end
            end else if ((state_q == GAP) && (gap_cnt_q != 4'd0)) begin
                gap_cnt_q <= gap_cnt_q - 4'd1;
            end
        end
    end

    // Output flags are registered copies of the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= (state_d == SEND);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign down.down_data  = data_q;
    assign down.down_valid = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign sent_cnt        = sent_cnt_q;

endmodule
